sseg_demux_capture: RTL

//  Receive end of the 4-digit time-multiplexed 7-seg bus: samples anode enables (active low)
//  and segment lines, and rebuilds the four per-digit patterns as parallel registers.

---
 rtl/sseg_demux_capture.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sseg_demux_capture.sv
// Rebuilds four 7-seg digit patterns from a time-multiplexed anode/segment bus.
// Optional hex decode outputs are enabled by defining SSEG_HEX_DECODE_EN.
module sseg_demux_capture #(
   parameter int SETTLE_CYCLES = 4,
   parameter int TIMEOUT_BITS  = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] an_in,
   input  logic [7:0] sseg_in,
   output logic [7:0] out0,
   output logic [7:0] out1,
   output logic [7:0] out2,
   output logic [7:0] out3,
   output logic [3:0] digit_valid,
   output logic       frame_done,
   output logic       enable_err,
   output logic       stale
`ifdef SSEG_HEX_DECODE_EN
   ,
   output logic [3:0] hex0,
   output logic [3:0] hex1,
   output logic [3:0] hex2,
   output logic [3:0] hex3,
   output logic [3:0] hex_ok
`endif
);

   localparam logic [7:0] CNT_MAX  = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] CNT_FIRE = 8'(SETTLE_CYCLES - 2);
   localparam logic [TIMEOUT_BITS-1:0] IDLE_MAX = '1;
   localparam logic [TIMEOUT_BITS-1:0] IDLE_PRE =
      {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

   logic [11:0] s1;
   logic [11:0] s2;
   logic [11:0] prev;
   logic [7:0]  cnt;
   logic [TIMEOUT_BITS-1:0] idle;
   logic [3:0]  seen;
   logic [7:0]  out_q [4];

   logic        same;
   logic        settle;
   logic [3:0]  an_s;
   logic [7:0]  seg_s;
   logic [3:0]  hit;
   logic        one_cold;
   logic        multi_low;
   logic        capture;
   logic        bad_en;
   logic [3:0]  seen_n;

   assign an_s   = s2[11:8];
   assign seg_s  = s2[7:0];
   assign same   = (s2 == prev);
   assign settle = same && (cnt == CNT_FIRE);

   always_comb begin
      hit = 4'b0000;
      unique case (an_s)
         4'b1110: hit = 4'b0001;
         4'b1101: hit = 4'b0010;
         4'b1011: hit = 4'b0100;
         4'b0111: hit = 4'b1000;
         default: hit = 4'b0000;
      endcase
   end

   assign one_cold  = |hit;
   assign multi_low = (an_s != 4'b1111) && !one_cold;
   assign capture   = settle && one_cold;
   assign bad_en    = settle && multi_low;
   assign seen_n    = seen | hit;

   // Two-flop synchroniser plus a compare register for dwell detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1   <= '1;
         s2   <= '1;
         prev <= '1;
         cnt  <= 8'd0;
      end else begin
         s1   <= {an_in, sseg_in};
         s2   <= s1;
         prev <= s2;
         if (!same)
            cnt <= 8'd0;
         else if (cnt < CNT_MAX)
            cnt <= cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 4; k++)
            out_q[k] <= 8'hFF;
         digit_valid <= 4'b0000;
         seen        <= 4'b0000;
         idle        <= '0;
         stale       <= 1'b0;
         frame_done  <= 1'b0;
         enable_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         enable_err <= bad_en;
         if (capture) begin
            for (int k = 0; k < 4; k++)
               if (hit[k])
                  out_q[k] <= seg_s;
            digit_valid <= digit_valid | hit;
            idle        <= '0;
            stale       <= 1'b0;
            if (seen_n == 4'b1111) begin
               seen       <= 4'b0000;
               frame_done <= 1'b1;
            end else begin
               seen <= seen_n;
            end
         end else if (idle != IDLE_MAX) begin
            idle <= idle + 1'b1;
            // Stale asserts together with the counter reaching all-ones
            if (idle == IDLE_PRE) begin
               stale       <= 1'b1;
               digit_valid <= 4'b0000;
               seen        <= 4'b0000;
            end
         end
      end
   end

   assign out0 = out_q[0];
   assign out1 = out_q[1];
   assign out2 = out_q[2];
   assign out3 = out_q[3];

`ifdef SSEG_HEX_DECODE_EN
   function automatic logic [4:0] hex_dec(input logic [6:0] s);
      logic [4:0] r;
      r = 5'h00;
      case (s)
         7'h40: r = {1'b1, 4'h0};
         7'h79: r = {1'b1, 4'h1};
         7'h24: r = {1'b1, 4'h2};
         7'h30: r = {1'b1, 4'h3};
         7'h19: r = {1'b1, 4'h4};
         7'h12: r = {1'b1, 4'h5};
         7'h02: r = {1'b1, 4'h6};
         7'h78: r = {1'b1, 4'h7};
         7'h00: r = {1'b1, 4'h8};
         7'h10: r = {1'b1, 4'h9};
         7'h08: r = {1'b1, 4'hA};
         7'h03: r = {1'b1, 4'hB};
         7'h46: r = {1'b1, 4'hC};
         7'h21: r = {1'b1, 4'hD};
         7'h06: r = {1'b1, 4'hE};
         7'h0E: r = {1'b1, 4'hF};
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   logic [4:0] dec;
   logic [3:0] hex_q [4];

   assign dec = hex_dec(seg_s[6:0]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 4; k++)
            hex_q[k] <= 4'h0;
         hex_ok <= 4'b0000;
      end else if (capture) begin
         for (int k = 0; k < 4; k++)
            if (hit[k]) begin
               hex_q[k]  <= dec[3:0];
               hex_ok[k] <= dec[4];
            end
      end
   end

   assign hex0 = hex_q[0];
   assign hex1 = hex_q[1];
   assign hex2 = hex_q[2];
   assign hex3 = hex_q[3];
`endif

endmodule
